// File: rtl/nurn_pkg.sv
// Shared types and encodings for the neuron-core sequencer.
// Holds the state enum, status-field codes and data-path select codes.
package nurn_pkg;

  typedef enum logic [3:0] {
    IDLE,
    R_INIT,
    R_BIAS,
    R_AXON,
    R_LAST,
    R_TH,
    R_WB,
    R_WBH,
    L_AXON,
    L_DRAIN,
    L_BRD,
    L_BWR
  } state_t;

  localparam logic [1:0] FLD_BIAS = 2'd0;
  localparam logic [1:0] FLD_POT  = 2'd1;
  localparam logic [1:0] FLD_HIST = 2'd2;

  localparam logic [1:0] SEL_ADD_W    = 2'd0;
  localparam logic [1:0] SEL_ADD_BIAS = 2'd1;
  localparam logic [1:0] SEL_ADD_POT  = 2'd2;

  localparam logic [1:0] SEL_WB_POT  = 2'd0;
  localparam logic [1:0] SEL_WB_BIAS = 2'd2;
  localparam logic [1:0] SEL_WB_HIST = 2'd3;

  // Every registered strobe, enable and select of the sequencer.
  typedef struct packed {
    logic       rst_acc;
    logic       acc_en;
    logic       cmp_th;
    logic       buff_memb_pot;
    logic       updt_post_spk_hist;
    logic       add_lrn_rt;
    logic       en_quant;
    logic       cmp_stdp;
    logic       buff_bias;
    logic       lrn_use_bias;
    logic [1:0] sel_rcl_add_b;
    logic [1:0] sel_wr_back_stat_b;
    logic       rd_cfg_a;
    logic       rd_cfg_b;
    logic       rd_cfg_c;
    logic       rd_stat_a;
    logic       wr_stat_b;
    logic       rd_stat_c;
    logic       wr_stat_d;
    logic       rd_stat_e;
    logic       rd_stat_f;
    logic       wr_stat_g;
  } ctl_t;

endpackage

// File: rtl/nurn_axon_cnt.sv
// Nested neuron/axon index counter with wrap and last-index flags.
// Exposes next-cycle indices so the sequencer can register addresses in step with its state.
module nurn_axon_cnt #(
  parameter int NUM_NURNS = 2,
  parameter int NUM_AXONS = 2,
  parameter int NW        = 1,
  parameter int AW        = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          axon_step_i,
  input  logic          nurn_step_i,
  output logic [NW-1:0] nurn_nxt_o,
  output logic [AW-1:0] axon_nxt_o,
  output logic          nurn_last_o,
  output logic          axon_last_o
);

  localparam logic [NW-1:0] NURN_LAST = NW'(NUM_NURNS - 1);
  localparam logic [AW-1:0] AXON_LAST = AW'(NUM_AXONS - 1);

  logic [NW-1:0] nurn_q, nurn_d;
  logic [AW-1:0] axon_q, axon_d;

  assign nurn_last_o = (nurn_q == NURN_LAST);
  assign axon_last_o = (axon_q == AXON_LAST);

  always_comb begin
    nurn_d = nurn_q;
    axon_d = axon_q;
    if (clr_i) begin
      nurn_d = '0;
      axon_d = '0;
    end else begin
      if (axon_step_i) axon_d = axon_last_o ? '0 : axon_q + AW'(1);
      if (nurn_step_i) nurn_d = nurn_last_o ? '0 : nurn_q + NW'(1);
    end
  end

  assign nurn_nxt_o = nurn_d;
  assign axon_nxt_o = axon_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      nurn_q <= '0;
      axon_q <= '0;
    end else begin
      nurn_q <= nurn_d;
      axon_q <= axon_d;
    end
  end

endmodule

// File: rtl/nurn_ctrlr.sv
// Neuron-core sequencer: per start pulse, recall then (NURN_CTRLR_LEARNING_EN) learning for every neuron.
// All outputs registered and decoded from the next state; no backpressure, start is ignored while busy.
module nurn_ctrlr
  import nurn_pkg::*;
#(
  parameter int NUM_NURNS          = 2,
  parameter int NUM_AXONS          = 2,
  parameter int NURN_CNT_BIT_WIDTH = 1,
  parameter int AXON_CNT_BIT_WIDTH = 1
) (
  input  logic                                         clk_i,
  input  logic                                         rst_n_i,
  input  logic                                         start_i,
  output logic                                         rstAcc_o,
  output logic                                         accEn_o,
  output logic                                         cmp_th_o,
  output logic                                         buffMembPot_o,
  output logic                                         updtPostSpkHist_o,
  output logic                                         addLrnRt_o,
  output logic                                         enQuant_o,
  output logic                                         cmpSTDP_o,
  output logic                                         buffBias_o,
  output logic                                         lrnUseBias_o,
  output logic [1:0]                                   sel_rclAdd_B_o,
  output logic [1:0]                                   sel_wrBackStat_B_o,
  input  logic                                         biasLrnMode_i,
  input  logic                                         NurnType_i,
  input  logic                                         axonLrnMode_i,
  output logic [NURN_CNT_BIT_WIDTH-1:0]                    Addr_Config_A_o,
  output logic                                         rdEn_Config_A_o,
  output logic [NURN_CNT_BIT_WIDTH-1:0]                    Addr_Config_B_o,
  output logic                                         rdEn_Config_B_o,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_Config_C_o,
  output logic                                         rdEn_Config_C_o,
  output logic [NURN_CNT_BIT_WIDTH+1:0]                    Addr_StatRd_A_o,
  output logic                                         rdEn_StatRd_A_o,
  output logic [NURN_CNT_BIT_WIDTH+1:0]                    Addr_StatWr_B_o,
  output logic                                         wrEn_StatWr_B_o,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_StatRd_C_o,
  output logic                                         rdEn_StatRd_C_o,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_StatWr_D_o,
  output logic                                         wrEn_StatWr_D_o,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_StatRd_E_o,
  output logic                                         rdEn_StatRd_E_o,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_StatRd_F_o,
  output logic                                         rdEn_StatRd_F_o,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_StatWr_G_o,
  output logic                                         wrEn_StatWr_G_o
);

  localparam int NW = NURN_CNT_BIT_WIDTH;
  localparam int AW = AXON_CNT_BIT_WIDTH;

  state_t           state_q, state_d;
  ctl_t             ctl_q, ctl_d;
  logic [NW-1:0]    cfg_addr_q, cfg_addr_d;
  logic [NW+1:0]    stat_a_addr_q, stat_a_addr_d;
  logic [NW+1:0]    stat_b_addr_q, stat_b_addr_d;
  logic [NW+AW-1:0] stat_e_addr_q, stat_e_addr_d;
  logic [NW+AW-1:0] lrn_rd_addr_q, lrn_rd_addr_d;
  logic [NW+AW-1:0] lrn_wr_addr_q, lrn_wr_addr_d;
  logic             bias_lrn_q, bias_lrn_d;
  logic             lrn_write;

  logic             cnt_clr, axon_step, nurn_step;
  logic [NW-1:0]    nurn_nxt;
  logic [AW-1:0]    axon_nxt;
  logic             nurn_last, axon_last;
  logic             unused_in;

  nurn_axon_cnt #(
    .NUM_NURNS (NUM_NURNS),
    .NUM_AXONS (NUM_AXONS),
    .NW        (NW),
    .AW        (AW)
  ) u_cnt (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clr_i       (cnt_clr),
    .axon_step_i (axon_step),
    .nurn_step_i (nurn_step),
    .nurn_nxt_o  (nurn_nxt),
    .axon_nxt_o  (axon_nxt),
    .nurn_last_o (nurn_last),
    .axon_last_o (axon_last)
  );

  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    axon_step  = 1'b0;
    nurn_step  = 1'b0;
    bias_lrn_d = bias_lrn_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = R_INIT;
          cnt_clr = 1'b1;
        end
      end
      R_INIT: state_d = R_BIAS;
      R_BIAS: begin
        state_d = R_AXON;
`ifdef NURN_CTRLR_LEARNING_EN
        // Config A read issued in R_INIT is valid now.
        bias_lrn_d = biasLrnMode_i;
`endif
      end
      R_AXON: begin
        axon_step = 1'b1;
        if (axon_last) state_d = R_LAST;
      end
      R_LAST: state_d = R_TH;
      R_TH:   state_d = R_WB;
      R_WB:   state_d = R_WBH;
`ifdef NURN_CTRLR_LEARNING_EN
      R_WBH: state_d = L_AXON;
      L_AXON: begin
        axon_step = 1'b1;
        if (axon_last) state_d = L_DRAIN;
      end
      L_DRAIN: state_d = L_BRD;
      L_BRD:   state_d = L_BWR;
      L_BWR: begin
        nurn_step = 1'b1;
        state_d   = nurn_last ? IDLE : R_INIT;
      end
`else
      R_WBH: begin
        nurn_step = 1'b1;
        state_d   = nurn_last ? IDLE : R_INIT;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctl_d                    = '0;
    ctl_d.sel_rcl_add_b      = ctl_q.sel_rcl_add_b;
    ctl_d.sel_wr_back_stat_b = ctl_q.sel_wr_back_stat_b;
    cfg_addr_d               = cfg_addr_q;
    stat_a_addr_d            = stat_a_addr_q;
    stat_b_addr_d            = stat_b_addr_q;
    stat_e_addr_d            = stat_e_addr_q;
    lrn_rd_addr_d            = lrn_rd_addr_q;
    lrn_wr_addr_d            = lrn_wr_addr_q;
    lrn_write                = 1'b0;
    case (state_d)
      R_INIT: begin
        ctl_d.rst_acc   = 1'b1;
        ctl_d.rd_cfg_a  = 1'b1;
        ctl_d.rd_cfg_b  = 1'b1;
        cfg_addr_d      = nurn_nxt;
        ctl_d.rd_stat_a = 1'b1;
        stat_a_addr_d   = {nurn_nxt, FLD_BIAS};
      end
      R_BIAS: begin
        ctl_d.acc_en        = 1'b1;
        ctl_d.sel_rcl_add_b = SEL_ADD_BIAS;
        ctl_d.buff_bias     = 1'b1;
        ctl_d.rd_stat_a     = 1'b1;
        stat_a_addr_d       = {nurn_nxt, FLD_POT};
      end
      R_AXON: begin
        ctl_d.rd_stat_e     = 1'b1;
        stat_e_addr_d       = {nurn_nxt, axon_nxt};
        ctl_d.acc_en        = 1'b1;
        // Potential read in R_BIAS lands in the first axon cycle.
        ctl_d.sel_rcl_add_b = (axon_nxt == '0) ? SEL_ADD_POT : SEL_ADD_W;
      end
      R_LAST: begin
        ctl_d.acc_en        = 1'b1;
        ctl_d.sel_rcl_add_b = SEL_ADD_W;
      end
      R_TH: begin
        ctl_d.cmp_th        = 1'b1;
        ctl_d.buff_memb_pot = 1'b1;
      end
      R_WB: begin
        ctl_d.wr_stat_b          = 1'b1;
        stat_b_addr_d            = {nurn_nxt, FLD_POT};
        ctl_d.sel_wr_back_stat_b = SEL_WB_POT;
        ctl_d.rd_stat_a          = 1'b1;
        stat_a_addr_d            = {nurn_nxt, FLD_HIST};
      end
      R_WBH: begin
        ctl_d.updt_post_spk_hist = 1'b1;
        ctl_d.wr_stat_b          = 1'b1;
        stat_b_addr_d            = {nurn_nxt, FLD_HIST};
        ctl_d.sel_wr_back_stat_b = SEL_WB_HIST;
      end
`ifdef NURN_CTRLR_LEARNING_EN
      L_AXON: begin
        ctl_d.rd_cfg_c  = 1'b1;
        ctl_d.rd_stat_c = 1'b1;
        ctl_d.rd_stat_f = 1'b1;
        lrn_rd_addr_d   = {nurn_nxt, axon_nxt};
        lrn_write       = (axon_nxt != '0);
      end
      L_DRAIN: lrn_write = 1'b1;
      L_BRD: begin
        if (bias_lrn_q) begin
          ctl_d.rd_stat_a    = 1'b1;
          stat_a_addr_d      = {nurn_nxt, FLD_BIAS};
          ctl_d.lrn_use_bias = 1'b1;
        end
      end
      L_BWR: begin
        if (bias_lrn_q) begin
          ctl_d.wr_stat_b          = 1'b1;
          stat_b_addr_d            = {nurn_nxt, FLD_BIAS};
          ctl_d.sel_wr_back_stat_b = SEL_WB_BIAS;
          ctl_d.lrn_use_bias       = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    // Write-back trails the read by one cycle, at the address read last cycle.
    if (lrn_write) begin
      ctl_d.cmp_stdp   = 1'b1;
      ctl_d.add_lrn_rt = 1'b1;
      ctl_d.en_quant   = 1'b1;
      ctl_d.wr_stat_d  = 1'b1;
      ctl_d.wr_stat_g  = 1'b1;
      lrn_wr_addr_d    = lrn_rd_addr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      ctl_q         <= '0;
      cfg_addr_q    <= '0;
      stat_a_addr_q <= '0;
      stat_b_addr_q <= '0;
      stat_e_addr_q <= '0;
      lrn_rd_addr_q <= '0;
      lrn_wr_addr_q <= '0;
      bias_lrn_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctl_q         <= ctl_d;
      cfg_addr_q    <= cfg_addr_d;
      stat_a_addr_q <= stat_a_addr_d;
      stat_b_addr_q <= stat_b_addr_d;
      stat_e_addr_q <= stat_e_addr_d;
      lrn_rd_addr_q <= lrn_rd_addr_d;
      lrn_wr_addr_q <= lrn_wr_addr_d;
      bias_lrn_q    <= bias_lrn_d;
    end
  end

`ifdef NURN_CTRLR_LEARNING_EN
  assign unused_in = ^{NurnType_i, axonLrnMode_i};
`else
  assign unused_in = ^{NurnType_i, axonLrnMode_i, biasLrnMode_i, bias_lrn_q};
`endif

  assign rstAcc_o           = ctl_q.rst_acc;
  assign accEn_o            = ctl_q.acc_en;
  assign cmp_th_o           = ctl_q.cmp_th;
  assign buffMembPot_o      = ctl_q.buff_memb_pot;
  assign updtPostSpkHist_o  = ctl_q.updt_post_spk_hist;
  assign addLrnRt_o         = ctl_q.add_lrn_rt;
  assign enQuant_o          = ctl_q.en_quant;
  assign cmpSTDP_o          = ctl_q.cmp_stdp;
  assign buffBias_o         = ctl_q.buff_bias;
  assign lrnUseBias_o       = ctl_q.lrn_use_bias;
  assign sel_rclAdd_B_o     = ctl_q.sel_rcl_add_b;
  assign sel_wrBackStat_B_o = ctl_q.sel_wr_back_stat_b;

  assign Addr_Config_A_o = cfg_addr_q;
  assign rdEn_Config_A_o = ctl_q.rd_cfg_a;
  assign Addr_Config_B_o = cfg_addr_q;
  assign rdEn_Config_B_o = ctl_q.rd_cfg_b;
  assign Addr_Config_C_o = lrn_rd_addr_q;
  assign rdEn_Config_C_o = ctl_q.rd_cfg_c;
  assign Addr_StatRd_A_o = stat_a_addr_q;
  assign rdEn_StatRd_A_o = ctl_q.rd_stat_a;
  assign Addr_StatWr_B_o = stat_b_addr_q;
  assign wrEn_StatWr_B_o = ctl_q.wr_stat_b;
  assign Addr_StatRd_C_o = lrn_rd_addr_q;
  assign rdEn_StatRd_C_o = ctl_q.rd_stat_c;
  assign Addr_StatWr_D_o = lrn_wr_addr_q;
  assign wrEn_StatWr_D_o = ctl_q.wr_stat_d;
  assign Addr_StatRd_E_o = stat_e_addr_q;
  assign rdEn_StatRd_E_o = ctl_q.rd_stat_e;
  assign Addr_StatRd_F_o = lrn_rd_addr_q;
  assign rdEn_StatRd_F_o = ctl_q.rd_stat_f;
  assign Addr_StatWr_G_o = lrn_wr_addr_q;
  assign wrEn_StatWr_G_o = ctl_q.wr_stat_g;

endmodule

// File: tb/tb_nurn_ctrlr.sv
// Bench for nurn_ctrlr: a per-cycle expected schedule is derived from the neuron/axon timeline
// and compared against every strobe, enable, address and select the sequencer drives.
module tb_nurn_ctrlr;

  localparam int NN = 2;
  localparam int NA = 2;
  localparam int NW = 1;
  localparam int AW = 1;
`ifdef NURN_CTRLR_LEARNING_EN
  localparam bit LRN = 1'b1;
`else
  localparam bit LRN = 1'b0;
`endif
  localparam int L     = LRN ? (2 * NA + 9) : (NA + 6);
  localparam int TOTAL = NN * L;
  localparam int MAXC  = TOTAL + 3;

  localparam int B_RSTACC = 0,  B_ACCEN = 1,  B_CMPTH = 2,  B_BUFMP = 3,  B_UPDT = 4;
  localparam int B_ADDLR  = 5,  B_ENQ   = 6,  B_STDP  = 7,  B_BUFB  = 8,  B_LUB  = 9;
  localparam int B_CA     = 10, B_CB    = 11, B_CC    = 12, B_SA    = 13, B_SB   = 14;
  localparam int B_SC     = 15, B_SD    = 16, B_SE    = 17, B_SF    = 18, B_SG   = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic biasLrnMode_i = 1'b0, NurnType_i = 1'b0, axonLrnMode_i = 1'b0;

  logic rstAcc_o, accEn_o, cmp_th_o, buffMembPot_o, updtPostSpkHist_o;
  logic addLrnRt_o, enQuant_o, cmpSTDP_o, buffBias_o, lrnUseBias_o;
  logic [1:0] sel_rclAdd_B_o, sel_wrBackStat_B_o;
  logic [NW-1:0] Addr_Config_A_o, Addr_Config_B_o;
  logic [NW+AW-1:0] Addr_Config_C_o, Addr_StatRd_C_o, Addr_StatWr_D_o;
  logic [NW+AW-1:0] Addr_StatRd_E_o, Addr_StatRd_F_o, Addr_StatWr_G_o;
  logic [NW+1:0] Addr_StatRd_A_o, Addr_StatWr_B_o;
  logic rdEn_Config_A_o, rdEn_Config_B_o, rdEn_Config_C_o, rdEn_StatRd_A_o, wrEn_StatWr_B_o;
  logic rdEn_StatRd_C_o, wrEn_StatWr_D_o, rdEn_StatRd_E_o, rdEn_StatRd_F_o, wrEn_StatWr_G_o;

  nurn_ctrlr #(
    .NUM_NURNS(NN), .NUM_AXONS(NA), .NURN_CNT_BIT_WIDTH(NW), .AXON_CNT_BIT_WIDTH(AW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i),
    .rstAcc_o(rstAcc_o), .accEn_o(accEn_o), .cmp_th_o(cmp_th_o),
    .buffMembPot_o(buffMembPot_o), .updtPostSpkHist_o(updtPostSpkHist_o),
    .addLrnRt_o(addLrnRt_o), .enQuant_o(enQuant_o), .cmpSTDP_o(cmpSTDP_o),
    .buffBias_o(buffBias_o), .lrnUseBias_o(lrnUseBias_o),
    .sel_rclAdd_B_o(sel_rclAdd_B_o), .sel_wrBackStat_B_o(sel_wrBackStat_B_o),
    .biasLrnMode_i(biasLrnMode_i), .NurnType_i(NurnType_i), .axonLrnMode_i(axonLrnMode_i),
    .Addr_Config_A_o(Addr_Config_A_o), .rdEn_Config_A_o(rdEn_Config_A_o),
    .Addr_Config_B_o(Addr_Config_B_o), .rdEn_Config_B_o(rdEn_Config_B_o),
    .Addr_Config_C_o(Addr_Config_C_o), .rdEn_Config_C_o(rdEn_Config_C_o),
    .Addr_StatRd_A_o(Addr_StatRd_A_o), .rdEn_StatRd_A_o(rdEn_StatRd_A_o),
    .Addr_StatWr_B_o(Addr_StatWr_B_o), .wrEn_StatWr_B_o(wrEn_StatWr_B_o),
    .Addr_StatRd_C_o(Addr_StatRd_C_o), .rdEn_StatRd_C_o(rdEn_StatRd_C_o),
    .Addr_StatWr_D_o(Addr_StatWr_D_o), .wrEn_StatWr_D_o(wrEn_StatWr_D_o),
    .Addr_StatRd_E_o(Addr_StatRd_E_o), .rdEn_StatRd_E_o(rdEn_StatRd_E_o),
    .Addr_StatRd_F_o(Addr_StatRd_F_o), .rdEn_StatRd_F_o(rdEn_StatRd_F_o),
    .Addr_StatWr_G_o(Addr_StatWr_G_o), .wrEn_StatWr_G_o(wrEn_StatWr_G_o)
  );

  always #5 clk = ~clk;

  logic [19:0] dut_en;
  assign dut_en = {wrEn_StatWr_G_o, rdEn_StatRd_F_o, rdEn_StatRd_E_o, wrEn_StatWr_D_o,
                   rdEn_StatRd_C_o, wrEn_StatWr_B_o, rdEn_StatRd_A_o, rdEn_Config_C_o,
                   rdEn_Config_B_o, rdEn_Config_A_o, lrnUseBias_o, buffBias_o, cmpSTDP_o,
                   enQuant_o, addLrnRt_o, updtPostSpkHist_o, buffMembPot_o, cmp_th_o,
                   accEn_o, rstAcc_o};

  logic [31:0] all_addr;
  assign all_addr = 32'({Addr_Config_A_o, Addr_Config_B_o, Addr_Config_C_o, Addr_StatRd_A_o,
                         Addr_StatWr_B_o, Addr_StatRd_C_o, Addr_StatWr_D_o, Addr_StatRd_E_o,
                         Addr_StatRd_F_o, Addr_StatWr_G_o, sel_rclAdd_B_o, sel_wrBackStat_B_o});

  int n_tests = 0;
  int n_fail  = 0;

  logic [19:0] exp_en [0:MAXC];
  int exp_ca [0:MAXC];
  int exp_sa [0:MAXC];
  int exp_sb [0:MAXC];
  int exp_se [0:MAXC];
  int exp_lr [0:MAXC];
  int exp_lw [0:MAXC];
  int exp_sel_add [0:MAXC];
  int exp_sel_wb [0:MAXC];
  bit bias_mode [NN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_en"}, 32'(dut_en), 32'd0);
    check({tag, "_addr"}, all_addr, 32'd0);
  endtask

  // Expected timeline: neuron n occupies cycles 1+n*L .. n*L+L after the start pulse.
  task automatic build_model();
    int b;
    for (int t = 0; t <= MAXC; t++) begin
      exp_en[t] = '0;
      exp_ca[t] = 0; exp_sa[t] = 0; exp_sb[t] = 0; exp_se[t] = 0;
      exp_lr[t] = 0; exp_lw[t] = 0; exp_sel_add[t] = 0; exp_sel_wb[t] = 0;
    end
    for (int n = 0; n < NN; n++) begin
      b = 1 + n * L;
      exp_en[b][B_RSTACC] = 1'b1; exp_en[b][B_CA] = 1'b1; exp_en[b][B_CB] = 1'b1;
      exp_ca[b] = n; exp_en[b][B_SA] = 1'b1; exp_sa[b] = n * 4;
      exp_en[b+1][B_ACCEN] = 1'b1; exp_sel_add[b+1] = 1; exp_en[b+1][B_BUFB] = 1'b1;
      exp_en[b+1][B_SA] = 1'b1; exp_sa[b+1] = n * 4 + 1;
      for (int a = 0; a < NA; a++) begin
        exp_en[b+2+a][B_SE] = 1'b1; exp_se[b+2+a] = n * NA + a;
        exp_en[b+2+a][B_ACCEN] = 1'b1; exp_sel_add[b+2+a] = (a == 0) ? 2 : 0;
      end
      exp_en[b+2+NA][B_ACCEN] = 1'b1; exp_sel_add[b+2+NA] = 0;
      exp_en[b+3+NA][B_CMPTH] = 1'b1; exp_en[b+3+NA][B_BUFMP] = 1'b1;
      exp_en[b+4+NA][B_SB] = 1'b1; exp_sb[b+4+NA] = n * 4 + 1; exp_sel_wb[b+4+NA] = 0;
      exp_en[b+4+NA][B_SA] = 1'b1; exp_sa[b+4+NA] = n * 4 + 2;
      exp_en[b+5+NA][B_UPDT] = 1'b1;
      exp_en[b+5+NA][B_SB] = 1'b1; exp_sb[b+5+NA] = n * 4 + 2; exp_sel_wb[b+5+NA] = 3;
      if (LRN) begin
        for (int a = 0; a < NA; a++) begin
          exp_en[b+6+NA+a][B_CC] = 1'b1; exp_en[b+6+NA+a][B_SC] = 1'b1;
          exp_en[b+6+NA+a][B_SF] = 1'b1; exp_lr[b+6+NA+a] = n * NA + a;
          exp_en[b+7+NA+a][B_STDP] = 1'b1; exp_en[b+7+NA+a][B_ADDLR] = 1'b1;
          exp_en[b+7+NA+a][B_ENQ] = 1'b1; exp_en[b+7+NA+a][B_SD] = 1'b1;
          exp_en[b+7+NA+a][B_SG] = 1'b1; exp_lw[b+7+NA+a] = n * NA + a;
        end
        if (bias_mode[n]) begin
          exp_en[b+7+2*NA][B_SA] = 1'b1; exp_sa[b+7+2*NA] = n * 4;
          exp_en[b+7+2*NA][B_LUB] = 1'b1;
          exp_en[b+8+2*NA][B_SB] = 1'b1; exp_sb[b+8+2*NA] = n * 4;
          exp_sel_wb[b+8+2*NA] = 2; exp_en[b+8+2*NA][B_LUB] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_cycle(input int t);
    check($sformatf("en@%0d", t), 32'(dut_en), 32'(exp_en[t]));
    if (exp_en[t][B_CA]) check($sformatf("cfgA@%0d", t), 32'(Addr_Config_A_o), exp_ca[t]);
    if (exp_en[t][B_CB]) check($sformatf("cfgB@%0d", t), 32'(Addr_Config_B_o), exp_ca[t]);
    if (exp_en[t][B_SA]) check($sformatf("statA@%0d", t), 32'(Addr_StatRd_A_o), exp_sa[t]);
    if (exp_en[t][B_SB]) begin
      check($sformatf("statB@%0d", t), 32'(Addr_StatWr_B_o), exp_sb[t]);
      check($sformatf("selWb@%0d", t), 32'(sel_wrBackStat_B_o), exp_sel_wb[t]);
    end
    if (exp_en[t][B_ACCEN]) check($sformatf("selAdd@%0d", t), 32'(sel_rclAdd_B_o), exp_sel_add[t]);
    if (exp_en[t][B_SE]) check($sformatf("statE@%0d", t), 32'(Addr_StatRd_E_o), exp_se[t]);
    if (exp_en[t][B_CC]) check($sformatf("cfgC@%0d", t), 32'(Addr_Config_C_o), exp_lr[t]);
    if (exp_en[t][B_SC]) check($sformatf("statC@%0d", t), 32'(Addr_StatRd_C_o), exp_lr[t]);
    if (exp_en[t][B_SF]) check($sformatf("statF@%0d", t), 32'(Addr_StatRd_F_o), exp_lr[t]);
    if (exp_en[t][B_SD]) check($sformatf("statD@%0d", t), 32'(Addr_StatWr_D_o), exp_lw[t]);
    if (exp_en[t][B_SG]) check($sformatf("statG@%0d", t), 32'(Addr_StatWr_G_o), exp_lw[t]);
  endtask

  // One full time step; mid_pulse is a cycle in which start is re-asserted while busy.
  task automatic run_step(input int mid_pulse);
    build_model();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    for (int t = 1; t <= TOTAL + 2; t++) begin
      @(negedge clk);
      check_cycle(t);
      biasLrnMode_i = (t <= TOTAL) ? bias_mode[(t - 1) / L] : 1'($urandom_range(0, 1));
      axonLrnMode_i = 1'($urandom_range(0, 1));
      NurnType_i    = 1'($urandom_range(0, 1));
      start_i       = (t == mid_pulse);
    end
    start_i = 1'b0;
  endtask

  initial begin
    // Reset held 3 cycles with start asserted throughout.
    start_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_zero("reset");
    end
    rst_n   = 1'b1;
    start_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_zero("post_reset");
    end

    for (int s = 0; s < 6; s++) begin
      for (int n = 0; n < NN; n++) begin
        if (s == 0)      bias_mode[n] = 1'b1;
        else if (s == 1) bias_mode[n] = 1'b0;
        else             bias_mode[n] = 1'($urandom_range(0, 1));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_step((s == 0) ? 0 : $urandom_range(2, TOTAL - 1));
    end

    // Reset in the middle of a step aborts with no further activity.
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      repeat ($urandom_range(3, TOTAL - 1)) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) begin
        @(negedge clk);
        check_zero("mid_reset");
      end
      rst_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check_zero("after_abort");
      end
    end

    // A clean step after the abort must start again from neuron 0.
    for (int n = 0; n < NN; n++) bias_mode[n] = 1'($urandom_range(0, 1));
    run_step(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
